// File: rtl/rr_mux_reg_if.sv
// Bundle of handshake and data signals between the channel producers,
// the arbitrating mux and the shared downstream consumer.
interface rr_mux_reg_if #(
    parameter int W   = 8,
    parameter int NCH = 4
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic             mode;
    logic [SELW-1:0]  sel;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;

    // Environment side: producers, select control and downstream consumer.
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered NCH-channel mux with valid/ready flow control. The granted
// channel comes from an external select (mode 0) or from a round-robin
// scan starting at ptr (mode 1). One output register stage, no skid buffer:
// in_ready is combinational from out_ready, in_valid, mode, sel and ptr.
module rr_mux_reg #(
    parameter int W   = 8,
    parameter int NCH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_mux_reg_if.slave   bus
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_gnt;
    logic            rr_found;
    logic [SELW-1:0] scan_idx;
    logic [SELW-1:0] gnt;
    logic            gnt_vld;
    logic            load_en;
    logic [W-1:0]    gnt_data;
    logic [NCH-1:0]  ready_c;

    logic [W-1:0]    data_q;
    logic [SELW-1:0] ch_q;
    logic            valid_q;

    // The output register can take a word when empty or being drained.
    assign load_en = !valid_q || bus.out_ready;

    // Round-robin scan: first valid channel at ptr, ptr+1, ... (mod NCH).
    // NCH is a power of two, so SELW-bit addition wraps for free.
    always_comb begin
        rr_gnt   = '0;
        rr_found = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = ptr + SELW'(k);
            if (!rr_found && bus.in_valid[scan_idx]) begin
                rr_gnt   = scan_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Grant selection; fixed mode never grants anything but sel.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (bus.mode) begin
            gnt     = rr_gnt;
            gnt_vld = rr_found;
        end else begin
            gnt     = bus.sel;
            gnt_vld = bus.in_valid[bus.sel];
        end
    end

    // Data of the granted channel, decoded without a variable part-select.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = bus.in_data[i*W +: W];
            end
        end
    end

    // One-hot ready towards the granted producer only.
    always_comb begin
        ready_c = '0;
        for (int i = 0; i < NCH; i++) begin
            ready_c[i] = load_en && gnt_vld && (gnt == SELW'(i));
        end
    end

    assign bus.in_ready = ready_c;

    // Output register: load on a transfer, empty when nothing is granted,
    // hold everything under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else if (load_en) begin
            if (gnt_vld) begin
                data_q  <= gnt_data;
                ch_q    <= gnt;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves past the winner, only on round-robin transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load_en && gnt_vld && bus.mode) begin
            ptr <= gnt + SELW'(1);
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (W=8, NCH=4) with hand-computed expectations.
module tb_rr_mux_reg;
    localparam int W   = 8;
    localparam int NCH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rr_mux_reg_if #(.W(W), .NCH(NCH)) bus ();

    rr_mux_reg #(.W(W), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] ch);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".data"},  32'(bus.out_data),  32'(d));
        check({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
    endtask

    logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] words  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = 4'b0000;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset.in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fixed mode, sel=2, all valid
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1 check("fixed.in_ready", 32'(bus.in_ready), 32'b0100);
        step();
        check_out("fixed.out", 1'b1, 8'h33, 2'd2);

        // Round-robin fairness from ptr=0 (fixed transfer left ptr alone)
        bus.mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 check("rr.in_ready", 32'(bus.in_ready), 32'(4'b0001 << rr_exp[k]));
            step();
            check_out("rr.out", 1'b1, words[rr_exp[k]], rr_exp[k]);
        end
        // ptr is now 2; move it to 3 with a single ch2 transfer
        bus.in_valid = 4'b0100;
        step();
        check_out("rr.to_ptr3", 1'b1, 8'h33, 2'd2);

        // Skip and wrap from ptr=3 with channels 0 and 2 valid: 0, 2, 0
        bus.in_valid = 4'b0101;
        step();
        check_out("wrap.a", 1'b1, 8'h11, 2'd0);
        step();
        check_out("wrap.b", 1'b1, 8'h33, 2'd2);
        step();
        check_out("wrap.c", 1'b1, 8'h11, 2'd0);

        // Load 0x22 (ptr=1 -> ch1), then backpressure for 3 cycles
        bus.in_valid = 4'b0010;
        step();
        check_out("bp.load", 1'b1, 8'h22, 2'd1);
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp.in_ready", 32'(bus.in_ready), 32'h0);
            step();
            check_out("bp.hold", 1'b1, 8'h22, 2'd1);
        end
        // Release: ptr=2 so ch2 loads in the same cycle, no bubble
        bus.out_ready = 1'b1;
        #1 check("bp.release_ready", 32'(bus.in_ready), 32'b0100);
        step();
        check_out("bp.nobubble", 1'b1, 8'h33, 2'd2);

        // Empty: valid drops, data holds
        bus.in_valid = 4'b0000;
        #1 check("empty.in_ready", 32'(bus.in_ready), 32'h0);
        step();
        check_out("empty.a", 1'b0, 8'h33, 2'd2);
        step();
        check_out("empty.b", 1'b0, 8'h33, 2'd2);

        // Fixed mode ignores other valid channels
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1011;
        #1 check("fixsel.none", 32'(bus.in_ready), 32'h0);
        step();
        check("fixsel.valid", 32'(bus.out_valid), 32'h0);
        bus.sel = 2'd3;
        #1 check("fixsel.ch3", 32'(bus.in_ready), 32'b1000);
        step();
        check_out("fixsel.out", 1'b1, 8'h44, 2'd3);

        // Back to round-robin: ptr still 3 after the fixed transfer
        bus.mode = 1'b1; bus.in_valid = 4'b1111;
        #1 check("rrback.in_ready", 32'(bus.in_ready), 32'b1000);
        step();
        check_out("rrback.out", 1'b1, 8'h44, 2'd3);

        // ptr=0 -> ch1 wins, leaving ptr=2 and out_data=0x22
        bus.in_valid = 4'b0010;
        step();
        check_out("ar.load", 1'b1, 8'h22, 2'd1);
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_out("ar.async", 1'b0, 8'h00, 2'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1 check("ar.first_ready", 32'(bus.in_ready), 32'b0001);
        step();
        check_out("ar.first", 1'b1, 8'h11, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised, registered N-channel multiplexer with valid/ready handshaking. It selects one of `NCH` input channels of width `W`, using either an externally driven select or round-robin arbitration, and presents the chosen word through a single output register stage. It sits between the partial-product/multiplier result producers and the shared downstream consumer. It generalises the combinational 4:1 mux into a flow-controlled, arbitrating channel combiner.

## Interface
Parameters:
- `W`, default 8: data width per channel (8 = full 4×4 product).
- `NCH`, default 4: number of input channels; power of two, ≥ 2.
- `SELW`, derived as `$clog2(NCH)`: select and channel-ID width; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `NCH*W`  channel i occupies bits `[i*W +: W]`.
- `in_valid`  in  `NCH`  per-channel valid.
- `in_ready`  out  `NCH`  per-channel ready (combinational).
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  `SELW`  channel used when `mode` = 0.
- `out_data`  out  `W`  registered selected word.
- `out_ch`  out  `SELW`  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts.

## Operation
- `load_en` = `!out_valid || out_ready`. The output register may load this cycle.
- Grant, fixed mode:
  - `gnt` = `sel`.
  - `gnt_vld` = `in_valid[sel]`.
  - Other channels are never granted, even if valid.
- Grant, round-robin mode:
  - `gnt` is the first i with `in_valid[i]`=1, scanning `ptr`, `ptr+1`, … mod `NCH`.
  - `gnt_vld` = `|in_valid`.
- `in_ready[i]` = `load_en && gnt_vld && (gnt == i)`. At most one bit is set per cycle.
- Input transfer on channel i: `in_valid[i] && in_ready[i]`.
- On each clock edge with `load_en`=1:
  - If `gnt_vld`: `out_data` ← `in_data[gnt]`, `out_ch` ← `gnt`, `out_valid` ← 1.
  - Else: `out_valid` ← 0; `out_data` and `out_ch` hold.
- With `load_en`=0, all output registers hold. `out_data` is stable while `out_valid && !out_ready`.
- `ptr` (SELW bits) updates only on a round-robin-mode transfer: `ptr` ← `gnt`+1, wrapping from `NCH`-1 to 0. Fixed-mode transfers leave `ptr` unchanged.
- `mode` and `sel` are sampled combinationally each cycle. A change takes effect on the very next grant and never corrupts a word already in the output register.
- Producers must hold `in_data`/`in_valid` stable until the transfer completes. The block does not check this.

## Timing
- Reset (`rst_n`=0, asynchronous): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. As a consequence, `in_ready` is 0 for any channel with `in_valid`=0.
- Reset asserted mid-transfer discards the held word. The first grant after release uses `ptr`=0.
- Latency: 1 cycle from input transfer to `out_valid`=1 with that word.
- Throughput: 1 word/cycle when `out_ready` is held high.
- `out_ready`=1 with `out_valid`=1 and a pending input gives simultaneous drain and load. There is no bubble.
- Backpressure: `out_ready`=0 with `out_valid`=1 forces all `in_ready` low in the same cycle.
- `in_ready` has a combinational path from `out_ready`, `in_valid`, `mode`, `sel`, and `ptr`. There is no skid buffer.
- `out_*` are driven directly from flops.

## Test plan
- Reset, then fixed mode with `sel`=2:
  - Stimulus: `in_valid`=4'b1111, `in_data` words {0x11, 0x22, 0x33, 0x44} for ch0..3, `out_ready`=1.
  - Required: only `in_ready[2]`=1; next cycle `out_data`=0x33, `out_ch`=2, `out_valid`=1.
- Round-robin fairness:
  - Stimulus: all four valid continuously, `out_ready`=1.
  - Required: `out_ch` sequence 0,1,2,3,0,1; one word per cycle.
- Round-robin skip and wrap:
  - Stimulus: `ptr`=3, `in_valid`=4'b0101.
  - Required: grant ch0, then ch2, then ch0.
- Backpressure:
  - Stimulus: `out_valid`=1 with `out_data`=0x22, `out_ready`=0 for 3 cycles.
  - Required: all `in_ready`=0 and `out_data` stays 0x22. On `out_ready`=1, the next word loads in the same cycle with no bubble.
- Empty:
  - Stimulus: `in_valid`=0, `out_ready`=1.
  - Required: `out_valid` drops to 0 one cycle after the last transfer; `out_data` holds.
- Async reset:
  - Stimulus: assert `rst_n`=0 mid-cycle while `out_valid`=1.
  - Required: `out_valid`=0 and `out_data`=0 immediately, before the next clock edge; after release, with all four channels valid, the first round-robin grant is ch0.
